bootrom_copy_engine: RTL and testbench
======================================

// Module: bootrom_copy_engine
// PURPOSE
//   Boot-time copy engine sitting directly downstream of bootrom_subsystem: masters its reg_req/reg_rsp port,
//   reads N 32-bit words from boot ROM and writes them word-by-word into on-chip SRAM over an OBI-style
//   req/gnt port. Lets the boot FSM or debug module shadow ROM code into RAM without CPU involvement.
// PARAMETERS
//   SrcAddrWidth  64  width of ROM-side byte address (matches reg_req_t.addr)
//   DstAddrWidth  32  width of SRAM-side byte address
//   DataWidth     32  word width on both sides; address stride = DataWidth/8
//   LenWidth      16  width of word-count field
//   reg_req_t     logic  register-interface request struct type (valid, write, addr, wdata, wstrb)
//   reg_rsp_t     logic  register-interface response struct type (ready, rdata, error)
// PORTS
//   clk_i        in   1             system clock
//   rst_i        in   1             synchronous, active-high reset
//   start_i      in   1             start pulse; sampled only in IDLE
//   src_addr_i   in   SrcAddrWidth  ROM byte start address, latched on accepted start
//   dst_addr_i   in   DstAddrWidth  SRAM byte start address, latched on accepted start
//   len_i        in   LenWidth      number of words to copy, latched on accepted start
//   busy_o       out  1             high while state != IDLE
//   done_o       out  1             one-cycle pulse at end of transfer (success or error)
//   err_o        out  1             sticky: ROM returned error; cleared on next accepted start
//   reg_req_o    out  reg_req_t     request to bootrom_subsystem
//   reg_rsp_i    in   reg_rsp_t     response from bootrom_subsystem
//   mem_req_o    out  1             SRAM request, held until mem_gnt_i
//   mem_gnt_i    in   1             SRAM grant
//   mem_we_o     out  1             always 1 when mem_req_o high
//   mem_be_o     out  DataWidth/8   all ones when mem_req_o high, else 0
//   mem_addr_o   out  DstAddrWidth  SRAM byte address
//   mem_wdata_o  out  DataWidth     word to write (buffered ROM data)
// BEHAVIOUR
//   Clock clk_i; reset is synchronous and active-high (rst_i). Reset: state IDLE, all outputs 0 (reg_req_o all fields 0).
//   FSM IDLE -> READ -> WRITE -> (READ | DONE) -> IDLE.
//   - IDLE: start_i=1 latches src/dst/len, clears err_o. len_i=0 -> DONE directly (no bus traffic); else READ.
//     start_i while busy_o=1 is ignored (no effect, no queueing).
//   - READ: reg_req_o.valid=1, write=0, wstrb=0, wdata=0, addr=cur_src. Held stable until reg_rsp_i.ready.
//     On ready&!error: rdata captured into word buffer -> WRITE. On ready&error: err_o<=1 -> DONE (no write).
//   - WRITE: mem_req_o=1, addr=cur_dst, wdata=buffer; held stable until mem_gnt_i. On gnt: cur_src+=DataWidth/8,
//     cur_dst+=DataWidth/8, remaining-=1; remaining was 1 -> DONE, else READ.
//   - DONE: done_o=1 for exactly one cycle, busy_o still 1; next cycle IDLE.
//   Never reg_req_o.valid and mem_req_o high in the same cycle.
//   Latency: start accepted at edge k -> first read request in cycle k+1; with ready/gnt tied high each word
//   takes 2 cycles; N-word copy: done_o in cycle k+1+2N; busy_o high for 2N+1 cycles after acceptance.
//   Address arithmetic: unsigned, wraps modulo 2^width (no error on wrap). Count uses LenWidth bits; len=2^LenWidth-1 legal.
//   Reset mid-transfer: at the reset edge state returns IDLE, requests drop next cycle, no done_o pulse, err_o cleared;
//   an un-granted SRAM write is abandoned.
// STRUCTURE
//   Package bootrom_copy_pkg: state enum copy_state_e {IDLE, READ, WRITE, DONE}, localparam StrideBytes.
//   Single module, no sub-modules; registers: state, cur_src, cur_dst, remaining, data buffer, err.
// TESTING
//   1) len=4, src=0x0, dst=0x1000, ready/gnt tied 1 -> SRAM writes at 0x1000..0x100C = ROM words 0..3, done_o in cycle k+9.
//   2) len=0 start -> no reg/mem request, done_o one cycle after acceptance, busy_o high 1 cycle.
//   3) len=2, mem_gnt_i delayed 3 cycles per write -> mem_addr/wdata stable while waiting, 2 writes, no extra reads.
//   4) ROM error on word 2 of len=5 -> exactly 2 SRAM writes, err_o=1, done_o pulse; next start clears err_o.
//   5) dst=0xFFFFFFFC, len=2 -> second write to 0x00000000 (wrap); start_i pulsed mid-copy ignored.
//   6) rst_i asserted during WRITE -> next cycle mem_req_o=0, busy_o=0, no done_o; fresh start copies correctly.

Source files
------------

// File: rtl/bootrom_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bootrom_copy_pkg
//  Description : Shared types for the boot ROM -> SRAM copy engine: FSM state
//                encoding, default word stride and the register-interface
//                request/response structs used by bootrom_subsystem.
//  Revision    : 1.0 - initial release
// ============================================================================
package bootrom_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_e;

    localparam int unsigned c_data_width   = 32;
    localparam int unsigned c_stride_bytes = c_data_width / 8;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

endpackage
`default_nettype wire

// File: rtl/bootrom_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : bootrom_copy_engine
//  Description : Copies len_i words from boot ROM (register interface,
//                read-only master) into SRAM (OBI-style req/gnt, write-only)
//                one word at a time: READ a word, WRITE it, repeat.
//  Ports       : clk_i/rst_i        clock, synchronous active-high reset
//                start_i, src/dst/len  transfer command, sampled in IDLE only
//                busy_o/done_o/err_o   status (done is a 1-cycle pulse,
//                                      err is sticky until the next start)
//                reg_req_o/reg_rsp_i   ROM-side register interface
//                mem_*                 SRAM-side write port
//  Revision    : 1.0 - initial release
// ============================================================================
module bootrom_copy_engine
    import bootrom_copy_pkg::*;
#(
    parameter int unsigned SRC_ADDR_WIDTH = 64,
    parameter int unsigned DST_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter type         REG_REQ_T      = reg_req_t,
    parameter type         REG_RSP_T      = reg_rsp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [SRC_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [DST_ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output REG_REQ_T                  reg_req_o,
    input  REG_RSP_T                  reg_rsp_i,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DST_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o
);

    localparam int unsigned c_stride = DATA_WIDTH / 8;

    copy_state_e               r_state;
    logic [SRC_ADDR_WIDTH-1:0] r_cur_src;
    logic [DST_ADDR_WIDTH-1:0] r_cur_dst;
    logic [LEN_WIDTH-1:0]      r_remaining;
    logic [DATA_WIDTH-1:0]     r_data_buf;
    logic                      r_err;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_mem_req;
    REG_REQ_T                  r_reg_req;

    logic [SRC_ADDR_WIDTH-1:0] w_next_src;
    logic [DST_ADDR_WIDTH-1:0] w_next_dst;

    // Unsigned wrap-around is intentional: no error on address overflow.
    assign w_next_src = r_cur_src + SRC_ADDR_WIDTH'(c_stride);
    assign w_next_dst = r_cur_dst + DST_ADDR_WIDTH'(c_stride);

    // All request/status outputs are registered and updated on the same edge
    // as the state, so the bus sees a request in the first cycle of a state
    // and the request stays stable until it is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_data_buf  <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_reg_req   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_cur_src   <= src_addr_i;
                        r_cur_dst   <= dst_addr_i;
                        r_remaining <= len_i;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state         <= READ;
                            r_reg_req.valid <= 1'b1;
                            r_reg_req.addr  <= src_addr_i;
                        end
                    end
                end
                READ: begin
                    if (reg_rsp_i.ready) begin
                        r_reg_req.valid <= 1'b0;
                        if (reg_rsp_i.error) begin
                            // A failed read aborts the copy; nothing is written.
                            r_err   <= 1'b1;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_data_buf <= reg_rsp_i.rdata;
                            r_mem_req  <= 1'b1;
                            r_state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_gnt_i) begin
                        r_mem_req   <= 1'b0;
                        r_cur_src   <= w_next_src;
                        r_cur_dst   <= w_next_dst;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state         <= READ;
                            r_reg_req.valid <= 1'b1;
                            r_reg_req.addr  <= w_next_src;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign reg_req_o   = r_reg_req;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_req;
    assign mem_be_o    = {(DATA_WIDTH/8){r_mem_req}};
    // Destination pointer only advances on grant, so it doubles as the
    // stable write address while a request is pending.
    assign mem_addr_o  = r_cur_dst;
    assign mem_wdata_o = r_data_buf;

endmodule
`default_nettype wire

// File: tb/tb_bootrom_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bootrom_copy_engine
//  Description : Directed self-checking bench for bootrom_copy_engine with a
//                behavioural ROM (data derived from address) and an SRAM
//                write monitor with programmable grant delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bootrom_copy_engine;
    import bootrom_copy_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [63:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    reg_req_t    reg_req;
    reg_rsp_t    reg_rsp;
    logic        mem_req, mem_gnt, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;

    int total = 0;
    int bad   = 0;

    bootrom_copy_engine dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .src_addr_i  (src_addr),
        .dst_addr_i  (dst_addr),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .reg_req_o   (reg_req),
        .reg_rsp_i   (reg_rsp),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (mem_gnt),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- ROM model ----------------
    logic        rom_err_en = 1'b0;
    logic [63:0] rom_err_addr = '0;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb begin
        reg_rsp = '0;
        if (reg_req.valid) begin
            reg_rsp.ready = 1'b1;
            reg_rsp.rdata = rom_word(reg_req.addr);
            reg_rsp.error = rom_err_en && (reg_req.addr == rom_err_addr);
        end
    end

    // ---------------- SRAM grant model ----------------
    int gnt_delay = 0;
    int wcnt = 0;
    always @(posedge clk_i) begin
        if (!mem_req || mem_gnt) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end
    assign mem_gnt = mem_req && (wcnt >= gnt_delay);

    // ---------------- monitor (samples on falling edge) ----------------
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          n_wr = 0, n_rd = 0, n_done = 0, n_busy = 0;
    int          n_overlap = 0, n_unstable = 0, n_badstrb = 0, done_cyc = -1;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0, pend_data = '0;

    always @(negedge clk_i) begin
        if (mem_req && mem_gnt) begin
            if (n_wr < 64) begin
                wr_addr[n_wr] = mem_addr;
                wr_data[n_wr] = mem_wdata;
            end
            n_wr++;
        end
        if (reg_req.valid && reg_rsp.ready) n_rd++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) n_busy++;
        if (reg_req.valid && mem_req) n_overlap++;
        if (mem_req && (mem_we !== 1'b1 || mem_be !== 4'hF)) n_badstrb++;
        if (reg_req.valid && (reg_req.write || reg_req.wstrb != '0 || reg_req.wdata != '0)) n_badstrb++;
        if (pend && mem_req && (mem_addr !== pend_addr || mem_wdata !== pend_data)) n_unstable++;
        pend      = mem_req && !mem_gnt;
        pend_addr = mem_addr;
        pend_data = mem_wdata;
    end

    // ---------------- helpers ----------------
    task automatic do_start(input logic [63:0] s, input logic [31:0] d,
                            input logic [15:0] l, output int c0);
        @(negedge clk_i);
        start_i  = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        @(negedge clk_i);
        start_i = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk_i);
        while (busy && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: busy=%0b expected 0", name, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%0b done=%0b err=%0b expected 0 0 0", busy, done, err);
        end
        total++;
        if (reg_req !== '0) begin
            bad++;
            $display("FAIL reset_reg_req: got %h expected 0", reg_req);
        end
        total++;
        if (mem_req !== 1'b0 || mem_be !== 4'h0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem: req=%0b be=%h we=%0b expected 0 0 0", mem_req, mem_be, mem_we);
        end
    endtask

    task automatic test_basic();
        int c0, w0, r0, d0, b0;
        w0 = n_wr; r0 = n_rd; d0 = n_done; b0 = n_busy;
        do_start(64'h0, 32'h0000_1000, 16'd4, c0);
        total++;
        if (reg_req.valid !== 1'b1 || reg_req.addr !== 64'h0) begin
            bad++;
            $display("FAIL basic_first_read: valid=%0b addr=%h expected 1 0", reg_req.valid, reg_req.addr);
        end
        wait_idle("basic");
        total++;
        if (n_wr - w0 != 4 || n_rd - r0 != 4) begin
            bad++;
            $display("FAIL basic_counts: writes=%0d reads=%0d expected 4 4", n_wr - w0, n_rd - r0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_addr[w0+i] !== 32'h1000 + 32'(4*i) || wr_data[w0+i] !== {16'hC0DE, 16'(4*i)}) begin
                bad++;
                $display("FAIL basic_word%0d: addr=%h data=%h expected %h %h", i, wr_addr[w0+i],
                         wr_data[w0+i], 32'h1000 + 32'(4*i), {16'hC0DE, 16'(4*i)});
            end
        end
        total++;
        if (n_done - d0 != 1 || done_cyc != c0 + 8) begin
            bad++;
            $display("FAIL basic_done: pulses=%0d at=%0d expected 1 at %0d", n_done - d0, done_cyc, c0 + 8);
        end
        total++;
        if (n_busy - b0 != 9 || err !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: busy_cycles=%0d err=%0b expected 9 0", n_busy - b0, err);
        end
    endtask

    task automatic test_zero_len();
        int c0, w0, r0, d0, b0;
        w0 = n_wr; r0 = n_rd; d0 = n_done; b0 = n_busy;
        do_start(64'h40, 32'h2000, 16'd0, c0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || reg_req.valid !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL zero_first_cycle: done=%0b busy=%0b valid=%0b req=%0b expected 1 1 0 0",
                     done, busy, reg_req.valid, mem_req);
        end
        wait_idle("zero");
        total++;
        if (n_wr != w0 || n_rd != r0 || n_done - d0 != 1 || n_busy - b0 != 1) begin
            bad++;
            $display("FAIL zero_counts: wr=%0d rd=%0d done=%0d busy=%0d expected 0 0 1 1",
                     n_wr - w0, n_rd - r0, n_done - d0, n_busy - b0);
        end
    endtask

    task automatic test_gnt_delay();
        int c0, w0, r0, u0;
        w0 = n_wr; r0 = n_rd; u0 = n_unstable;
        gnt_delay = 3;
        do_start(64'h100, 32'h2000, 16'd2, c0);
        wait_idle("gnt_delay");
        gnt_delay = 0;
        total++;
        if (n_wr - w0 != 2 || n_rd - r0 != 2 || n_unstable != u0) begin
            bad++;
            $display("FAIL gnt_delay_counts: wr=%0d rd=%0d unstable=%0d expected 2 2 0",
                     n_wr - w0, n_rd - r0, n_unstable - u0);
        end
        total++;
        if (wr_addr[w0] !== 32'h2000 || wr_data[w0] !== 32'hC0DE_0100 ||
            wr_addr[w0+1] !== 32'h2004 || wr_data[w0+1] !== 32'hC0DE_0104) begin
            bad++;
            $display("FAIL gnt_delay_data: %h=%h %h=%h expected 2000=c0de0100 2004=c0de0104",
                     wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]);
        end
    endtask

    task automatic test_rom_error();
        int c0, w0, r0, d0;
        w0 = n_wr; r0 = n_rd; d0 = n_done;
        rom_err_en   = 1'b1;
        rom_err_addr = 64'h48;
        do_start(64'h40, 32'h3000, 16'd5, c0);
        wait_idle("rom_error");
        rom_err_en = 1'b0;
        total++;
        if (n_wr - w0 != 2 || n_rd - r0 != 3 || n_done - d0 != 1 || err !== 1'b1) begin
            bad++;
            $display("FAIL rom_error_result: wr=%0d rd=%0d done=%0d err=%0b expected 2 3 1 1",
                     n_wr - w0, n_rd - r0, n_done - d0, err);
        end
        total++;
        if (wr_addr[w0+1] !== 32'h3004 || wr_data[w0+1] !== 32'hC0DE_0044) begin
            bad++;
            $display("FAIL rom_error_word1: addr=%h data=%h expected 3004 c0de0044",
                     wr_addr[w0+1], wr_data[w0+1]);
        end
        w0 = n_wr;
        do_start(64'h80, 32'h3100, 16'd1, c0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL rom_error_clear: err=%0b expected 0", err);
        end
        wait_idle("rom_error_retry");
        total++;
        if (n_wr - w0 != 1 || wr_data[w0] !== 32'hC0DE_0080 || err !== 1'b0) begin
            bad++;
            $display("FAIL rom_error_retry: wr=%0d data=%h err=%0b expected 1 c0de0080 0",
                     n_wr - w0, wr_data[w0], err);
        end
    endtask

    task automatic test_wrap();
        int c0, w0, d0, b0;
        w0 = n_wr; d0 = n_done; b0 = n_busy;
        do_start(64'h200, 32'hFFFF_FFFC, 16'd2, c0);
        @(negedge clk_i);
        start_i  = 1'b1;
        len      = 16'd7;
        dst_addr = 32'h5000;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle("wrap");
        repeat (4) @(negedge clk_i);
        total++;
        if (wr_addr[w0] !== 32'hFFFF_FFFC || wr_addr[w0+1] !== 32'h0000_0000 ||
            wr_data[w0+1] !== 32'hC0DE_0204) begin
            bad++;
            $display("FAIL wrap_addr: a0=%h a1=%h d1=%h expected fffffffc 00000000 c0de0204",
                     wr_addr[w0], wr_addr[w0+1], wr_data[w0+1]);
        end
        total++;
        if (n_wr - w0 != 2 || n_done - d0 != 1 || n_busy - b0 != 5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_ignore_start: wr=%0d done=%0d busy_cycles=%0d busy=%0b expected 2 1 5 0",
                     n_wr - w0, n_done - d0, n_busy - b0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int c0, w0, d0, n;
        w0 = n_wr; d0 = n_done;
        gnt_delay = 3;
        do_start(64'h300, 32'h6000, 16'd3, c0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_reach_write: mem_req=%0b expected 1", mem_req);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i     = 1'b0;
        gnt_delay = 0;
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || reg_req.valid !== 1'b0 ||
            n_done != d0 || n_wr != w0) begin
            bad++;
            $display("FAIL reset_mid_abort: req=%0b busy=%0b err=%0b valid=%0b done=%0d wr=%0d expected 0 0 0 0 0 0",
                     mem_req, busy, err, reg_req.valid, n_done - d0, n_wr - w0);
        end
        do_start(64'h300, 32'h6000, 16'd2, c0);
        wait_idle("reset_mid_fresh");
        total++;
        if (n_wr - w0 != 2 || wr_addr[w0+1] !== 32'h6004 || wr_data[w0+1] !== 32'hC0DE_0304) begin
            bad++;
            $display("FAIL reset_mid_fresh: wr=%0d a1=%h d1=%h expected 2 6004 c0de0304",
                     n_wr - w0, wr_addr[w0+1], wr_data[w0+1]);
        end
    endtask

    task automatic test_bus_rules();
        total++;
        if (n_overlap != 0 || n_badstrb != 0) begin
            bad++;
            $display("FAIL bus_rules: overlap=%0d bad_ctrl=%0d expected 0 0", n_overlap, n_badstrb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_gnt_delay();
        test_rom_error();
        test_wrap();
        test_reset_mid();
        test_bus_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
